// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered RV64I ALU-control decode stage with 2-entry skid buffer
//
// Decodes a 32-bit RV64I instruction into the 5-bit ALU function code and
// operand selects, and holds up to two decoded entries so that backpressure
// from execute never forms a combinational path back to in_ready.
//
// Ports:
//   clk, reset_n            core clock (rising edge), asynchronous active-low reset
//   flush                   synchronous discard of all buffered entries
//   in_valid/in_ready       upstream handshake (in_ready is a flop)
//   in_inst, in_pc          raw instruction and its PC
//   out_valid/out_ready     downstream handshake
//   out_alu_function        [4]=32-bit shamt range, [3]=SUB/SRA, [2:0]=group
//   out_op_a_sel            00 rs1, 01 pc, 10 zero
//   out_op_b_sel            0 rs2, 1 immediate
//   out_is_word             OP-32/OP-IMM-32 result is sign-extended from bit 31
//   out_illegal             instruction not decodable
//   out_pc                  forwarded in_pc
//
// Build option: define ALU_CTRL_STRICT_ENC_EN to flag reserved funct7 /
// shift-immediate encodings as illegal instead of ignoring those bits.

module alu_ctrl_stage #(
    parameter int XLEN       = 64,
    parameter int SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_alu_function,
    output logic [1:0]      out_op_a_sel,
    output logic            out_op_b_sel,
    output logic            out_is_word,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam logic [1:0] DEPTH = SKID_DEPTH[1:0];

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      fn;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic            is_word;
        logic            illegal;
    } entry_t;

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f3_sub_sra;   // funct3 000/101: inst[30] selects SUB/SRA
    logic       f3_shift;     // funct3 001/101: shift-immediate forms
    logic       f3_word_ok;   // funct3 legal for the *W opcodes

    assign opcode     = in_inst[6:0];
    assign f3         = in_inst[14:12];
    assign f7         = in_inst[31:25];
    assign f3_sub_sra = (f3 == 3'b000) || (f3 == 3'b101);
    assign f3_shift   = (f3 == 3'b001) || (f3 == 3'b101);
    assign f3_word_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);

    logic rr_rsvd;          // reserved OP/OP-32 funct7 use
    logic imm_shift_rsvd;   // reserved OP-IMM shift upper bits
    logic immw_shift_rsvd;  // reserved OP-IMM-32 shift upper bits

`ifdef ALU_CTRL_STRICT_ENC_EN
    logic f7_bad;
    assign f7_bad          = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
    assign rr_rsvd         = f7_bad || ((f7 == 7'b0100000) && !f3_sub_sra);
    assign imm_shift_rsvd  = f3_shift &&
                             !((in_inst[31:26] == 6'b000000) || (in_inst[31:26] == 6'b010000));
    assign immw_shift_rsvd = f3_shift && (in_inst[25] || f7_bad);
`else
    assign rr_rsvd         = 1'b0;
    assign imm_shift_rsvd  = 1'b0;
    assign immw_shift_rsvd = 1'b0;
`endif

    // Fields only some build options look at.
    logic unused_decode_bits;
    assign unused_decode_bits = ^{f7, f3_shift, in_inst[29:15], in_inst[11:7]};

    entry_t dec;
    logic   dec_ill;

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec.fn  = {1'b0, f3_sub_sra & in_inst[30], f3};
                dec_ill = rr_rsvd;
            end
            OPC_OP_IMM: begin
                dec.fn    = {1'b0, (f3 == 3'b101) & in_inst[30], f3};
                dec.b_sel = 1'b1;
                dec_ill   = imm_shift_rsvd;
            end
            OPC_OP_32: begin
                dec.fn      = {1'b1, f3_sub_sra & in_inst[30], f3};
                dec.is_word = 1'b1;
                dec_ill     = !f3_word_ok || rr_rsvd;
            end
            OPC_OP_IMM_32: begin
                dec.fn      = {1'b1, (f3 == 3'b101) & in_inst[30], f3};
                dec.b_sel   = 1'b1;
                dec.is_word = 1'b1;
                dec_ill     = !f3_word_ok || immw_shift_rsvd;
            end
            OPC_LOAD, OPC_STORE, OPC_JALR: begin
                dec.b_sel = 1'b1;
            end
            OPC_AUIPC, OPC_JAL: begin
                dec.a_sel = 2'b01;
                dec.b_sel = 1'b1;
            end
            OPC_LUI: begin
                dec.a_sel = 2'b10;
                dec.b_sel = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3[2:1])
                    2'b00:   dec.fn = 5'b01000;
                    2'b10:   dec.fn = 5'b00010;
                    2'b11:   dec.fn = 5'b00011;
                    default: dec_ill = 1'b1;
                endcase
            end
            // Also covers every opcode with inst[1:0] != 2'b11.
            default: dec_ill = 1'b1;
        endcase

        if (dec_ill) begin
            dec.fn      = 5'b00000;
            dec.a_sel   = 2'b00;
            dec.b_sel   = 1'b0;
            dec.is_word = 1'b0;
        end
        dec.illegal = dec_ill;
    end

    // ------------------------------------------------------------------
    // Two-entry shift FIFO; ent0 is the head and drives the outputs.
    // ------------------------------------------------------------------
    entry_t     ent0_q, ent0_d;
    entry_t     ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;

    logic push;
    logic pop;

    assign push = in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        ent0_d  = dec;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        ent0_d = dec;
                    end else if (push) begin
                        ent1_d  = dec;
                        count_d = 2'd2;
                    end else if (pop) begin
                        count_d = 2'd0;
                    end
                end
                default: begin
                    // in_ready is low when full, so only a pop can happen here.
                    if (pop) begin
                        ent0_d  = ent1_q;
                        count_d = 2'd1;
                    end
                end
            endcase
        end
        in_ready_d = count_d < DEPTH;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent0_q     <= '0;
            ent1_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = count_q != 2'd0;
    assign out_alu_function = ent0_q.fn;
    assign out_op_a_sel     = ent0_q.a_sel;
    assign out_op_b_sel     = ent0_q.b_sel;
    assign out_is_word      = ent0_q.is_word;
    assign out_illegal      = ent0_q.illegal;
    assign out_pc           = ent0_q.pc;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb/tb_alu_ctrl_stage.sv - directed self-checking bench for alu_ctrl_stage

module tb_alu_ctrl_stage;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_alu_function;
    logic [1:0]      out_op_a_sel;
    logic            out_op_b_sel;
    logic            out_is_word;
    logic            out_illegal;
    logic [XLEN-1:0] out_pc;

    int checks = 0;
    int errors = 0;

    alu_ctrl_stage #(.XLEN(XLEN), .SKID_DEPTH(2)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_alu_function (out_alu_function),
        .out_op_a_sel     (out_op_a_sel),
        .out_op_b_sel     (out_op_b_sel),
        .out_is_word      (out_is_word),
        .out_illegal      (out_illegal),
        .out_pc           (out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the head entry: valid, function, selects, word, illegal, pc.
    task automatic check_head(input string tag, input logic [4:0] fn, input logic [1:0] a,
                              input logic b, input logic w, input logic ill,
                              input logic [63:0] pc);
        check({tag, ".valid"}, {63'b0, out_valid}, 64'd1);
        check({tag, ".fn"}, {59'b0, out_alu_function}, {59'b0, fn});
        check({tag, ".a"}, {62'b0, out_op_a_sel}, {62'b0, a});
        check({tag, ".b"}, {63'b0, out_op_b_sel}, {63'b0, b});
        check({tag, ".word"}, {63'b0, out_is_word}, {63'b0, w});
        check({tag, ".ill"}, {63'b0, out_illegal}, {63'b0, ill});
        check({tag, ".pc"}, out_pc, pc);
    endtask

    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_SUB   = 32'h403100B3;
    localparam logic [31:0] I_SRAIW = 32'h4031509B;
    localparam logic [31:0] I_SLLW  = 32'h003110BB;
    localparam logic [31:0] I_BLTU  = 32'h0020E063;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_AUIPC = 32'h00001097;
    localparam logic [31:0] I_F7ODD = 32'h023100B3;
    localparam logic [31:0] I_BR010 = 32'h0020A063;

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst.valid", {63'b0, out_valid}, 64'd0);
        check("rst.ready", {63'b0, in_ready}, 64'd1);
        check("rst.fn", {59'b0, out_alu_function}, 64'd0);
        check("rst.pc", out_pc, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // add, then sub / sraiw back-to-back with out_ready high
        in_valid = 1'b1; in_inst = I_ADD; in_pc = 64'h100; out_ready = 1'b1;
        @(negedge clk);
        check_head("add", 5'b00000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h100);
        check("add.ready", {63'b0, in_ready}, 64'd1);
        in_inst = I_SUB; in_pc = 64'h104;
        @(negedge clk);
        check_head("sub", 5'b01000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h104);
        check("sub.ready", {63'b0, in_ready}, 64'd1);
        in_inst = I_SRAIW; in_pc = 64'h108;
        @(negedge clk);
        check_head("sraiw", 5'b11101, 2'b00, 1'b1, 1'b1, 1'b0, 64'h108);
        check("sraiw.ready", {63'b0, in_ready}, 64'd1);
        in_inst = I_SLLW; in_pc = 64'h10C;
        @(negedge clk);
        check_head("sllw", 5'b10001, 2'b00, 1'b0, 1'b1, 1'b0, 64'h10C);
        in_valid = 1'b0;
        @(negedge clk);
        check("drain.valid", {63'b0, out_valid}, 64'd0);

        // Backpressure: three offered, two accepted, released in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = I_BLTU; in_pc = 64'h200;
        @(negedge clk);
        check("bp1.ready", {63'b0, in_ready}, 64'd1);
        in_inst = I_LUI; in_pc = 64'h204;
        @(negedge clk);
        check("bp2.ready", {63'b0, in_ready}, 64'd0);
        check_head("bp2.bltu", 5'b00011, 2'b00, 1'b0, 1'b0, 1'b0, 64'h200);
        in_inst = I_AUIPC; in_pc = 64'h208;
        @(negedge clk);
        check("bp3.ready", {63'b0, in_ready}, 64'd0);
        check_head("bp3.bltu", 5'b00011, 2'b00, 1'b0, 1'b0, 1'b0, 64'h200);
        out_ready = 1'b1;
        @(negedge clk);
        check_head("rel.lui", 5'b00000, 2'b10, 1'b1, 1'b0, 1'b0, 64'h204);
        check("rel.ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        check_head("rel.auipc", 5'b00000, 2'b01, 1'b1, 1'b0, 1'b0, 64'h208);
        in_valid = 1'b0;
        @(negedge clk);
        check("rel.empty", {63'b0, out_valid}, 64'd0);

        // Flush a full buffer with an input offered and a pop requested
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = I_ADD; in_pc = 64'h300;
        @(negedge clk);
        in_inst = I_SUB; in_pc = 64'h304;
        @(negedge clk);
        check("full.ready", {63'b0, in_ready}, 64'd0);
        flush = 1'b1; out_ready = 1'b1; in_inst = I_LUI; in_pc = 64'h308;
        @(negedge clk);
        check("flush.valid", {63'b0, out_valid}, 64'd0);
        check("flush.ready", {63'b0, in_ready}, 64'd1);
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush.after", {63'b0, out_valid}, 64'd0);

        // Reserved / illegal encodings
        in_valid = 1'b1; in_inst = I_F7ODD; in_pc = 64'h400;
        @(negedge clk);
`ifdef ALU_CTRL_STRICT_ENC_EN
        check_head("f7odd", 5'b00000, 2'b00, 1'b0, 1'b0, 1'b1, 64'h400);
`else
        check_head("f7odd", 5'b00000, 2'b00, 1'b0, 1'b0, 1'b0, 64'h400);
`endif
        in_inst = I_BR010; in_pc = 64'h404;
        @(negedge clk);
        check_head("br010", 5'b00000, 2'b00, 1'b0, 1'b0, 1'b1, 64'h404);
        in_inst = 32'h00000000; in_pc = 64'h408;
        @(negedge clk);
        check_head("zero", 5'b00000, 2'b00, 1'b0, 1'b0, 1'b1, 64'h408);

        // Asynchronous reset mid-operation
        out_ready = 1'b0; in_inst = I_SUB; in_pc = 64'h500;
        @(negedge clk);
        check("pre_rst.valid", {63'b0, out_valid}, 64'd1);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("arst.valid", {63'b0, out_valid}, 64'd0);
        check("arst.ready", {63'b0, in_ready}, 64'd1);
        check("arst.fn", {59'b0, out_alu_function}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst.valid", {63'b0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
